// File: rtl/hazard_pkg.sv
// Purpose : shared types and constants for the Tuse/Tnew hazard scoreboard.
// Latency : n/a (types, constants and pure helper functions only).
// Backpr. : n/a.
package hazard_pkg;

    // Field widths of the shadow stage record. The top-level REG_W/TNEW_W
    // parameters must match these.
    localparam int SB_REG_W  = 5;
    localparam int SB_TNEW_W = 2;

    // Forwarding mux select codes, shared by the D and E stage muxes.
    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    // Tuse per consumer class: cycles from D until the operand is needed.
    localparam logic [SB_TNEW_W-1:0] TUSE_BRANCH = 2'd0;  // beq / jr compare in D
    localparam logic [SB_TNEW_W-1:0] TUSE_ALU    = 2'd1;  // ALU operand in E
    localparam logic [SB_TNEW_W-1:0] TUSE_STORE  = 2'd2;  // sw data in M

    // Tnew per producer class: cycles after entering E until forwardable.
    localparam logic [SB_TNEW_W-1:0] TNEW_JAL  = 2'd0;
    localparam logic [SB_TNEW_W-1:0] TNEW_ALU  = 2'd1;
    localparam logic [SB_TNEW_W-1:0] TNEW_LOAD = 2'd2;

    // Destination/source info shadowed through E, M and W.
    typedef struct packed {
        logic                 valid;
        logic [SB_REG_W-1:0]  dst;
        logic                 wen;
        logic [SB_TNEW_W-1:0] tnew;
        logic [SB_REG_W-1:0]  rs;
        logic [SB_REG_W-1:0]  rt;
        logic                 md_start;
        logic                 md_div;
    } stage_t;

    // Tnew after one pipeline advance, saturating at zero.
    function automatic logic [SB_TNEW_W-1:0] tnew_step(input logic [SB_TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // A stage produces register r; $0 is never produced.
    function automatic logic stage_writes(input stage_t s, input logic [SB_REG_W-1:0] r);
        return s.valid & s.wen & (s.dst == r) & (r != '0);
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Purpose : busy tracker for the multi-cycle multiply/divide unit.
// Latency : busy asserts combinationally while the start is in E, counter loads as it leaves E.
// Backpr. : none; the scoreboard stalls HI/LO users while busy.
// Ports   : clk, reset (sync, active-high), i_e_md_start / i_e_md_div (valid E-stage
//           start and its divide flag), o_md_busy.
module md_busy_tracker #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_e_md_start,
    input  logic i_e_md_div,
    output logic o_md_busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_e_md_start) begin
            r_cnt <= i_e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // The start sitting in E counts as busy so a HI/LO access right behind
    // it is held before the counter has been loaded.
    assign o_md_busy = (r_cnt != '0) | i_e_md_start;

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose : Tuse/Tnew stall and forwarding controller for the 5-stage pipeline.
// Latency : stall/fwd/md_busy combinational from D inputs and registered E/M/W shadow state.
// Backpr. : stall freezes PC and D and injects a bubble into E.
// Ports   : clk, reset (sync, active-high); D-stage decode info (d_rs/d_rt with use
//           and tuse, d_dst/d_wen/d_tnew, d_md_start/d_md_div/d_md_access);
//           outputs stall, fwd_rs_d/fwd_rt_d/fwd_rs_e/fwd_rt_e (2-bit codes),
//           fwd_rt_m, md_busy.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W       = SB_REG_W,
    parameter int TNEW_W      = SB_TNEW_W,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  d_rs,
    input  logic [REG_W-1:0]  d_rt,
    input  logic              d_rs_use,
    input  logic              d_rt_use,
    input  logic [TNEW_W-1:0] d_rs_tuse,
    input  logic [TNEW_W-1:0] d_rt_tuse,
    input  logic [REG_W-1:0]  d_dst,
    input  logic              d_wen,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              d_md_access,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m,
    output logic              md_busy
);

    stage_t r_e, r_m, r_w;
    stage_t w_d;
    logic   w_rs_hz, w_rt_hz, w_md_hz, w_md_busy;

    // Nearest producer wins. A not-yet-ready nearest producer selects GRF
    // rather than falling through to an older, stale copy; the stall logic
    // or a later forwarding point supplies the right value.
    function automatic logic [1:0] fwd_pick(input logic [SB_REG_W-1:0] r,
                                            input stage_t e, input stage_t m, input stage_t w);
        logic [1:0] sel;
        sel = FWD_GRF;
        if (stage_writes(e, r))
            sel = (e.tnew == '0) ? FWD_E : FWD_GRF;
        else if (stage_writes(m, r))
            sel = (m.tnew == '0) ? FWD_M : FWD_GRF;
        else if (stage_writes(w, r))
            sel = (w.tnew == '0) ? FWD_W : FWD_GRF;
        return sel;
    endfunction

    always_comb begin
        w_d          = '0;
        w_d.valid    = 1'b1;
        w_d.dst      = d_dst;
        w_d.wen      = d_wen;
        w_d.tnew     = d_tnew;
        w_d.rs       = d_rs;
        w_d.rt       = d_rt;
        w_d.md_start = d_md_start;
        w_d.md_div   = d_md_div;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e <= '0;
            r_m <= '0;
            r_w <= '0;
        end else begin
            r_e      <= stall ? '0 : w_d;
            r_m      <= r_e;
            r_m.tnew <= tnew_step(r_e.tnew);
            r_w      <= r_m;
            r_w.tnew <= '0;   // anything in W is already in the writeback register
        end
    end

    md_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy (
        .clk          (clk),
        .reset        (reset),
        .i_e_md_start (r_e.valid & r_e.md_start),
        .i_e_md_div   (r_e.md_div),
        .o_md_busy    (w_md_busy)
    );

    // E and M are checked independently: either one still being too far
    // from its result is enough to hold the consumer in D.
    always_comb begin
        w_rs_hz = d_rs_use &
                  ((stage_writes(r_e, d_rs) & (r_e.tnew > d_rs_tuse)) |
                   (stage_writes(r_m, d_rs) & (r_m.tnew > d_rs_tuse)));
        w_rt_hz = d_rt_use &
                  ((stage_writes(r_e, d_rt) & (r_e.tnew > d_rt_tuse)) |
                   (stage_writes(r_m, d_rt) & (r_m.tnew > d_rt_tuse)));
        w_md_hz = (d_md_access | d_md_start) & w_md_busy;
    end

    assign stall    = w_rs_hz | w_rt_hz | w_md_hz;
    assign md_busy  = w_md_busy;

    assign fwd_rs_d = fwd_pick(d_rs, r_e, r_m, r_w);
    assign fwd_rt_d = fwd_pick(d_rt, r_e, r_m, r_w);
    // E consumers only look at older stages; an empty stage never matches.
    assign fwd_rs_e = fwd_pick(r_e.rs, '0, r_m, r_w);
    assign fwd_rt_e = fwd_pick(r_e.rt, '0, r_m, r_w);
    assign fwd_rt_m = stage_writes(r_w, r_m.rt);

endmodule
